// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard_ctrl pipeline sequencing controller.
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } hc_state_e;

   localparam int REG_AW_DEF = 5;
   localparam int PERF_CNT_W = 16;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard_ctrl signal bundle; master is the datapath side, slave the controller.
interface hazard_ctrl_if
#(
   parameter int REG_AW = hazard_ctrl_pkg::REG_AW_DEF
);
   logic [REG_AW-1:0] ID_Rs;
   logic [REG_AW-1:0] ID_Rt;
   logic [REG_AW-1:0] EX_Rd;
   logic              ID_UsesRt;
   logic              EX_MemRead;
   logic              M_Branch;
   logic              M_BNE;
   logic              M_ZeroFlag;
   // Memory handshake: M_MemRead/M_MemWrite act as valid and DMemReady as ready;
   // an access completes in the cycle where both are high, otherwise the pipe freezes.
   logic              M_MemRead;
   logic              M_MemWrite;
   logic              DMemReady;

   logic              PCWrite;
   logic              PCSrc;
   logic              IF_ID_Write;
   logic              IF_ID_Flush;
   logic              ID_EX_Bubble;
   logic              EX_MEM_Flush;
   logic              PipeHold;
   logic              MemError;

   modport master (
      output ID_Rs, ID_Rt, EX_Rd, ID_UsesRt, EX_MemRead,
             M_Branch, M_BNE, M_ZeroFlag, M_MemRead, M_MemWrite, DMemReady,
      input  PCWrite, PCSrc, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble,
             EX_MEM_Flush, PipeHold, MemError
   );

   modport slave (
      input  ID_Rs, ID_Rt, EX_Rd, ID_UsesRt, EX_MemRead,
             M_Branch, M_BNE, M_ZeroFlag, M_MemRead, M_MemWrite, DMemReady,
      output PCWrite, PCSrc, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble,
             EX_MEM_Flush, PipeHold, MemError
   );
endinterface

// File: rtl/hazard_ctrl_mem_wait_timer.sv
// Counts MEM_WAIT cycles; timeout flags the cycle whose increment reaches MEM_TIMEOUT.
module mem_wait_timer
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic timeout
);
   localparam int            CW   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);
   localparam logic [CW-1:0] TOP  = CW'(MEM_TIMEOUT);

   logic [CW-1:0] cnt_q, cnt_d;

   // Saturates at MEM_TIMEOUT instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && cnt_q != TOP) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout = en && (cnt_q == LAST);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stalls, flushes and memory freeze for the 5-stage MIPS pipe.
// Optional HAZARD_PERF_CNT_EN adds saturating StallCycles/FlushEvents counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_AW      = REG_AW_DEF,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                  Clk,
   input  logic                  Reset,
   hazard_ctrl_if.slave          bus,
`ifdef HAZARD_PERF_CNT_EN
   output logic [PERF_CNT_W-1:0] StallCycles,
   output logic [PERF_CNT_W-1:0] FlushEvents,
`endif
   output hc_state_e             DbgState
);
   logic [REG_AW-1:0] id_rs, id_rt, ex_rd;
   logic branch_taken, load_use, mem_pend;
   logic wait_timeout;
   hc_state_e state_q, state_d;
   logic mem_error_q, mem_error_d;
   logic pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_hold;

   assign id_rs = bus.ID_Rs;
   assign id_rt = bus.ID_Rt;
   assign ex_rd = bus.EX_Rd;

   assign branch_taken = (bus.M_Branch & bus.M_ZeroFlag) | (bus.M_BNE & ~bus.M_ZeroFlag);
   assign load_use     = bus.EX_MemRead & (ex_rd != '0) &
                         ((ex_rd == id_rs) | (bus.ID_UsesRt & (ex_rd == id_rt)));
   assign mem_pend     = (bus.M_MemRead | bus.M_MemWrite) & ~bus.DMemReady;

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk     (Clk),
      .rst     (Reset),
      .clr     (state_q == RUN),
      .en      (state_q == MEM_WAIT),
      .timeout (wait_timeout)
   );

   // Controls act on the same edge as the registers they drive, so they are combinational.
   always_comb begin
      pc_write     = 1'b1;
      pc_src       = 1'b0;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_flush = 1'b0;
      pipe_hold    = 1'b0;
      if (Reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (state_q != RUN || mem_pend) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_hold   = 1'b1;
      end else if (branch_taken) begin
         // The flushed ID instruction makes any simultaneous load-use moot.
         pc_src       = 1'b1;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (load_use) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:      if (mem_pend) state_d = MEM_WAIT;
         MEM_WAIT: begin
            if (bus.DMemReady)      state_d = RUN;
            else if (wait_timeout)  state_d = ERROR;
         end
         ERROR:    state_d = ERROR;
         default:  state_d = RUN;
      endcase
      mem_error_d = mem_error_q | (state_d == ERROR);
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [PERF_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [PERF_CNT_W-1:0] flush_events_q, flush_events_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_events_d = flush_events_q;
      if (!pc_write && stall_cycles_q != '1) begin
         stall_cycles_d = stall_cycles_q + PERF_CNT_W'(1);
      end
      if (pc_src && flush_events_q != '1) begin
         flush_events_d = flush_events_q + PERF_CNT_W'(1);
      end
   end

   assign StallCycles = stall_cycles_q;
   assign FlushEvents = flush_events_q;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q        <= RUN;
         mem_error_q    <= 1'b0;
`ifdef HAZARD_PERF_CNT_EN
         stall_cycles_q <= '0;
         flush_events_q <= '0;
`endif
      end else begin
         state_q        <= state_d;
         mem_error_q    <= mem_error_d;
`ifdef HAZARD_PERF_CNT_EN
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
`endif
      end
   end

   assign bus.PCWrite      = pc_write;
   assign bus.PCSrc        = pc_src;
   assign bus.IF_ID_Write  = if_id_write;
   assign bus.IF_ID_Flush  = if_id_flush;
   assign bus.ID_EX_Bubble = id_ex_bubble;
   assign bus.EX_MEM_Flush = ex_mem_flush;
   assign bus.PipeHold     = pipe_hold;
   assign bus.MemError     = mem_error_q;
   assign DbgState         = state_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, hand-written multi-cycle sequences, random vs reference model.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   localparam int TMO = 4;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       ex_memread;
      logic [4:0] ex_rd;
      logic       m_branch;
      logic       m_bne;
      logic       m_zero;
      logic       m_memread;
      logic       m_memwrite;
      logic       dmem_ready;
   } in_t;

   typedef struct {
      string      name;
      in_t        in;
      logic [7:0] exp;
   } vec_t;

   // Output vector bit order: PCWrite PCSrc IF_ID_Write IF_ID_Flush ID_EX_Bubble EX_MEM_Flush PipeHold MemError
   localparam logic [7:0] O_NORM   = 8'b1010_0000;
   localparam logic [7:0] O_BRANCH = 8'b1111_1100;
   localparam logic [7:0] O_LU     = 8'b0000_1000;
   localparam logic [7:0] O_FROZEN = 8'b0000_0010;
   localparam logic [7:0] O_RESET  = 8'b0001_1100;

   logic Clk = 1'b0;
   logic Reset;
   hc_state_e dbg_state;
`ifdef HAZARD_PERF_CNT_EN
   logic [PERF_CNT_W-1:0] stall_cycles, flush_events;
`endif

   hazard_ctrl_if #(.REG_AW(5)) bus ();

   hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(TMO)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .bus         (bus),
`ifdef HAZARD_PERF_CNT_EN
      .StallCycles (stall_cycles),
      .FlushEvents (flush_events),
`endif
      .DbgState    (dbg_state)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic in_t mk(logic [4:0] rs, logic [4:0] rt, logic uses_rt, logic exmr,
                              logic [4:0] exrd, logic br, logic bne, logic z,
                              logic mr, logic mw, logic rdy);
      in_t v;
      v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.ex_memread = exmr; v.ex_rd = exrd;
      v.m_branch = br; v.m_bne = bne; v.m_zero = z;
      v.m_memread = mr; v.m_memwrite = mw; v.dmem_ready = rdy;
      return v;
   endfunction

   task automatic drive(in_t v);
      bus.ID_Rs      = v.rs;
      bus.ID_Rt      = v.rt;
      bus.ID_UsesRt  = v.uses_rt;
      bus.EX_MemRead = v.ex_memread;
      bus.EX_Rd      = v.ex_rd;
      bus.M_Branch   = v.m_branch;
      bus.M_BNE      = v.m_bne;
      bus.M_ZeroFlag = v.m_zero;
      bus.M_MemRead  = v.m_memread;
      bus.M_MemWrite = v.m_memwrite;
      bus.DMemReady  = v.dmem_ready;
   endtask

   function automatic logic [7:0] get_out();
      return {bus.PCWrite, bus.PCSrc, bus.IF_ID_Write, bus.IF_ID_Flush,
              bus.ID_EX_Bubble, bus.EX_MEM_Flush, bus.PipeHold, bus.MemError};
   endfunction

   // Check outputs mid-cycle, then advance past the next rising edge.
   task automatic cyc(string name, logic [7:0] exp_o, hc_state_e exp_s);
      #2;
      chk({name, "_out"}, 32'(get_out()), 32'(exp_o));
      chk({name, "_state"}, 32'(dbg_state), 32'(exp_s));
      @(posedge Clk);
      #1;
   endtask

   // Reference model: outputs straight from the rule priorities.
   function automatic logic [7:0] ref_out(in_t v, logic rst, hc_state_e mode, logic err);
      logic bt, lu, mp;
      bt = (v.m_branch && v.m_zero) || (v.m_bne && !v.m_zero);
      lu = v.ex_memread && (v.ex_rd != 5'd0) &&
           ((v.ex_rd == v.rs) || (v.uses_rt && v.ex_rd == v.rt));
      mp = (v.m_memread || v.m_memwrite) && !v.dmem_ready;
      if (rst) return {7'b0001110, err};
      if (mode != RUN || mp) return {7'b0000001, err};
      if (bt) return O_BRANCH;
      if (lu) return O_LU;
      return O_NORM;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[13];
      in_t  z, v;
      hc_state_e m_mode;
      int   m_waited;
      logic m_err, rst;
      logic [7:0] e;
      int   m_stall, m_flush;

      z = '0;
      tbl[0]  = '{"idle",          z,                                              O_NORM};
      tbl[1]  = '{"lu_rs",         mk(8, 0, 0, 1, 8, 0, 0, 0, 0, 0, 1),            O_LU};
      tbl[2]  = '{"lu_after_bub",  mk(8, 0, 0, 0, 8, 0, 0, 0, 0, 0, 1),            O_NORM};
      tbl[3]  = '{"rd_zero",       mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1),            O_NORM};
      tbl[4]  = '{"lu_rt",         mk(3, 8, 1, 1, 8, 0, 0, 0, 0, 0, 1),            O_LU};
      tbl[5]  = '{"rt_unused",     mk(3, 8, 0, 1, 8, 0, 0, 0, 0, 0, 1),            O_NORM};
      tbl[6]  = '{"beq_taken",     mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1),            O_BRANCH};
      tbl[7]  = '{"bne_not_taken", mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1),            O_NORM};
      tbl[8]  = '{"bne_taken",     mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1),            O_BRANCH};
      tbl[9]  = '{"beq_not_taken", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1),            O_NORM};
      tbl[10] = '{"branch_and_lu", mk(8, 0, 0, 1, 8, 1, 0, 1, 0, 0, 1),            O_BRANCH};
      tbl[11] = '{"mem_ready",     mk(1, 2, 1, 0, 5, 0, 0, 0, 1, 0, 1),            O_NORM};
      tbl[12] = '{"memw_ready_lu", mk(9, 0, 0, 1, 9, 0, 0, 0, 0, 1, 1),            O_LU};

      // Reset behaviour
      Reset = 1'b1;
      drive(z);
      @(posedge Clk);
      #1;
      cyc("reset", O_RESET, RUN);
      Reset = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].in);
         cyc(tbl[i].name, tbl[i].exp, RUN);
      end

      // Memory wait with a load-use pending underneath it
      v = mk(8, 0, 0, 1, 8, 0, 0, 0, 1, 0, 0);
      drive(v);
      cyc("mw0", O_FROZEN, RUN);
      cyc("mw1", O_FROZEN, MEM_WAIT);
      cyc("mw2", O_FROZEN, MEM_WAIT);
      v.dmem_ready = 1'b1;
      drive(v);
      cyc("mw3_ready", O_FROZEN, MEM_WAIT);
      v.m_memread = 1'b0;
      drive(v);
      cyc("mw_lu_release", O_LU, RUN);
      drive(z);
      cyc("mw_after", O_NORM, RUN);

      // Reset during MEM_WAIT
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      cyc("rw0", O_FROZEN, RUN);
      Reset = 1'b1;
      cyc("rw_reset", O_RESET, MEM_WAIT);
      Reset = 1'b0;
      drive(z);
      cyc("rw_after", O_NORM, RUN);

      // Timeout into ERROR, sticky until reset
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      for (int i = 0; i <= TMO; i++) begin
         cyc($sformatf("tmo%0d", i), O_FROZEN, (i == 0) ? RUN : MEM_WAIT);
      end
      cyc("tmo_err", O_FROZEN | 8'h01, ERROR);
      drive(z);
      cyc("err_sticky", O_FROZEN | 8'h01, ERROR);
      Reset = 1'b1;
      cyc("err_reset", O_RESET | 8'h01, ERROR);
      Reset = 1'b0;
      cyc("err_cleared", O_NORM, RUN);

`ifdef HAZARD_PERF_CNT_EN
      Reset = 1'b1;
      cyc("perf_reset", O_RESET, RUN);
      Reset = 1'b0;
      chk("perf_stall_zero", 32'(stall_cycles), 0);
      chk("perf_flush_zero", 32'(flush_events), 0);
      drive(tbl[10].in);
      cyc("perf_br_lu", O_BRANCH, RUN);
      drive(z);
      chk("perf_flush_one", 32'(flush_events), 1);
      chk("perf_stall_same", 32'(stall_cycles), 0);
`endif

      // Random stimulus against the reference model
      Reset = 1'b1;
      drive(z);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      m_mode = RUN; m_waited = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         v.rs         = 5'($urandom_range(0, 3));
         v.rt         = 5'($urandom_range(0, 3));
         v.ex_rd      = 5'($urandom_range(0, 3));
         v.uses_rt    = 1'($urandom_range(0, 1));
         v.ex_memread = 1'($urandom_range(0, 1));
         v.m_branch   = 1'($urandom_range(0, 1));
         v.m_bne      = 1'($urandom_range(0, 1));
         v.m_zero     = 1'($urandom_range(0, 1));
         v.m_memread  = ($urandom_range(0, 3) == 0);
         v.m_memwrite = ($urandom_range(0, 3) == 0);
         v.dmem_ready = ($urandom_range(0, 9) < 6);
         Reset = rst;
         drive(v);
         #2;
         e = ref_out(v, rst, m_mode, m_err);
         chk("rand_out", 32'(get_out()), 32'(e));
         chk("rand_state", 32'(dbg_state), 32'(m_mode));
`ifdef HAZARD_PERF_CNT_EN
         chk("rand_stall", 32'(stall_cycles), 32'(m_stall));
         chk("rand_flush", 32'(flush_events), 32'(m_flush));
`endif
         @(posedge Clk);
         #1;
         if (rst) begin
            m_mode = RUN; m_waited = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
         end else begin
            if (!e[7] && m_stall < 65535) m_stall++;
            if (e[6] && m_flush < 65535) m_flush++;
            if (m_mode == RUN) begin
               if ((v.m_memread || v.m_memwrite) && !v.dmem_ready) begin
                  m_mode = MEM_WAIT;
                  m_waited = 0;
               end
            end else if (m_mode == MEM_WAIT) begin
               if (v.dmem_ready) begin
                  m_mode = RUN;
               end else begin
                  m_waited++;
                  if (m_waited == TMO) begin
                     m_mode = ERROR;
                     m_err = 1'b1;
                  end
               end
            end
         end
      end
      Reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
